snake_frame_sched: RTL and testbench
====================================

Name: snake_frame_sched

Overview:
- Top-level frame scheduler and game-stage controller for the snake game.
- Generates the periodic frame tick and advances the game stage (title, board init, playing, game over).
- Sequences the per-frame work: board-update engine first, then the VGA draw engine, via req/done handshakes.
- Drives the `stage` and `isDrawing` signals consumed by the drawing datapath.

Parameters:
- FRAME_CYCLES, 1000000: clock cycles per frame period; tick period is exactly this value.
- MOVE_DIV_INIT, 8: frames per snake move at level 0.
- MOVE_DIV_MIN, 2: floor for frames per move.
- FOOD_PER_LEVEL, 4: foods eaten per level increment.
- CW, 20: width of frame counter; must satisfy 2^CW > FRAME_CYCLES.

Ports:
- clock  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- start_btn  in  1  synchronised, debounced start level; design rising-edge detects it
- init_done  in  1  board-init engine finished (1-cycle pulse)
- upd_done  in  1  update engine finished one move (1-cycle pulse)
- collision  in  1  sampled only in the cycle upd_done=1
- ate_food  in  1  sampled only in the cycle upd_done=1
- draw_done  in  1  draw engine finished one frame (1-cycle pulse)
- rstage  out  32  current stage code, zero-extended
- init_req  out  1  1-cycle pulse starting board init
- upd_req  out  1  1-cycle pulse starting one move
- isDrawing  out  1  high from draw start until draw_done
- level  out  4  current level, saturates at 15
- overrun  out  1  sticky; set when a tick arrives while a frame is still busy

Behaviour:
- Reset values (async on resetn=0):
  - stage=TITLE(0)
  - all req outputs and isDrawing=0
  - level=0, overrun=0
  - frame counter=0, move counter=0, food counter=0
  - move divider=MOVE_DIV_INIT
  - internal start-button edge register=0
- Stage codes: TITLE=0, INIT=1, PLAYING=2, GAME_OVER=3.
- Frame tick:
  - Counter increments every cycle in every stage.
  - At FRAME_CYCLES-1 the counter wraps to 0 and tick=1 for that cycle.
- Stage transitions:
  - TITLE: start_btn rising edge -> INIT; init_req pulses in the same cycle as the transition.
  - INIT: init_done -> PLAYING; clear level, food counter and move counter; move divider=MOVE_DIV_INIT.
  - PLAYING: upd_done with collision=1 -> GAME_OVER. The draw for that frame still runs.
  - GAME_OVER: start_btn rising edge -> INIT with an init_req pulse.
- Frame sub-FSM (runs in every stage): F_IDLE, F_UPD, F_DRAW.
  - F_IDLE on tick, PLAYING, move counter==move divider-1: pulse upd_req, reset move counter, go F_UPD.
  - F_IDLE on tick, any other case: increment move counter (PLAYING only), assert isDrawing, go F_DRAW. TITLE, INIT and GAME_OVER still draw every frame.
  - F_UPD on upd_done: evaluate collision and ate_food, assert isDrawing, go F_DRAW.
  - F_DRAW on draw_done: clear isDrawing, go F_IDLE.
- Food and level arithmetic:
  - ate_food increments the food counter.
  - When the counter reaches FOOD_PER_LEVEL: counter=0, level+=1 (saturating), move divider=max(divider-1, MOVE_DIV_MIN).
- Overrun:
  - A tick seen in F_UPD or F_DRAW sets overrun (sticky until reset) and is dropped.
  - The frame sub-FSM is unaffected.
- Simultaneous events:
  - upd_done with collision=1 and ate_food=1: the collision wins the stage change, and the food still counts.
  - start_btn edge in PLAYING or INIT is ignored.
- Stage changes never abort an in-flight update or draw; the handshake always completes.
- Reset mid-frame returns to TITLE/F_IDLE immediately. Engines must treat resetn as their own reset.

Decomposition:
- Package snake_pkg holds:
  - stage encoding constants (TITLE/INIT/PLAYING/GAME_OVER)
  - frame-FSM state type
  - parameter defaults
- Natural sub-module: snake_frame_timer (frame counter plus tick pulse, parameterised by FRAME_CYCLES). The rest stays in snake_frame_sched.

Test Plan:
- Reset release with FRAME_CYCLES=10 -> rstage=0.
  - First tick at cycle 9, then every 10 cycles.
  - isDrawing rises the cycle after each tick and falls the cycle after draw_done.
- start_btn edge in TITLE -> init_req pulse, rstage=1; init_done -> rstage=2, level=0.
- PLAYING with MOVE_DIV_INIT=3 -> upd_req every 3rd tick; other ticks go straight to draw.
- Four upd_done with ate_food=1, FOOD_PER_LEVEL=4 -> level=1 and move spacing drops to 2.
  - Repeat until the spacing holds at MOVE_DIV_MIN=2.
- upd_done with collision=1 and ate_food=1 -> rstage=3, food counted, draw still issued.
  - A following start_btn edge -> init_req pulse, rstage=1.
- draw_done withheld past the next tick -> overrun=1 and that tick is dropped.
  - Assert resetn=0 mid-draw -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared types and defaults for the snake game frame scheduler.
package snake_pkg;

    localparam int FRAME_CYCLES_DEF   = 1000000;
    localparam int MOVE_DIV_INIT_DEF  = 8;
    localparam int MOVE_DIV_MIN_DEF   = 2;
    localparam int FOOD_PER_LEVEL_DEF = 4;
    localparam int CW_DEF             = 20;

    // Width of the move counter, move divider and food counter.
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        ST_TITLE     = 2'd0,
        ST_INIT      = 2'd1,
        ST_PLAYING   = 2'd2,
        ST_GAME_OVER = 2'd3
    } stage_e;

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_UPD  = 2'd1,
        F_DRAW = 2'd2
    } frame_e;

    // One step faster, but never below the floor: max(div-1, floor).
    function automatic logic [CNT_W-1:0] div_step_down(
        input logic [CNT_W-1:0] div,
        input logic [CNT_W-1:0] floor_val
    );
        logic [CNT_W-1:0] res;
        if (div > floor_val) begin
            res = div - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            res = floor_val;
        end
        return res;
    endfunction

endpackage

// File: rtl/snake_frame_timer.sv
// Free-running frame counter; tick is high for the last cycle of each frame.
module snake_frame_timer
    import snake_pkg::*;
#(
    parameter int FRAME_CYCLES = FRAME_CYCLES_DEF,
    parameter int CW           = CW_DEF
) (
    input  logic clock,
    input  logic resetn,
    output logic tick
);

    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_CYCLES - 1);

    logic [CW-1:0] cnt_r;

    assign tick = (cnt_r == LAST_CNT);

    // Count every cycle, wrapping to zero on the tick cycle.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_r <= {CW{1'b0}};
        end else if (tick) begin
            cnt_r <= {CW{1'b0}};
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

endmodule

// File: rtl/snake_frame_sched.sv
// Game-stage controller and per-frame update/draw sequencer for snake.
module snake_frame_sched
    import snake_pkg::*;
#(
    parameter int FRAME_CYCLES   = FRAME_CYCLES_DEF,
    parameter int MOVE_DIV_INIT  = MOVE_DIV_INIT_DEF,
    parameter int MOVE_DIV_MIN   = MOVE_DIV_MIN_DEF,
    parameter int FOOD_PER_LEVEL = FOOD_PER_LEVEL_DEF,
    parameter int CW             = CW_DEF
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start_btn,
    input  logic        init_done,
    input  logic        upd_done,
    input  logic        collision,
    input  logic        ate_food,
    input  logic        draw_done,
    output logic [31:0] rstage,
    output logic        init_req,
    output logic        upd_req,
    output logic        isDrawing,
    output logic [3:0]  level,
    output logic        overrun
);

    localparam logic [CNT_W-1:0] DIV_INIT  = CNT_W'(MOVE_DIV_INIT);
    localparam logic [CNT_W-1:0] DIV_MIN   = CNT_W'(MOVE_DIV_MIN);
    localparam logic [CNT_W-1:0] FOOD_LAST = CNT_W'(FOOD_PER_LEVEL - 1);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    stage_e            stage_r,    stage_s;
    frame_e            frame_r,    frame_s;
    logic [3:0]        level_r,    level_s;
    logic [CNT_W-1:0]  food_r,     food_s;
    logic [CNT_W-1:0]  move_r,     move_s;
    logic [CNT_W-1:0]  div_r,      div_s;
    logic              init_req_r, init_req_s;
    logic              upd_req_r,  upd_req_s;
    logic              drawing_r,  drawing_s;
    logic              overrun_r,  overrun_s;
    logic              btn_q_r;
    logic              btn_edge_s;
    logic              tick_s;

    snake_frame_timer #(
        .FRAME_CYCLES (FRAME_CYCLES),
        .CW           (CW)
    ) u_timer (
        .clock  (clock),
        .resetn (resetn),
        .tick   (tick_s)
    );

    assign btn_edge_s = start_btn & ~btn_q_r;

    assign rstage    = {30'd0, 2'(stage_r)};
    assign init_req  = init_req_r;
    assign upd_req   = upd_req_r;
    assign isDrawing = drawing_r;
    assign level     = level_r;
    assign overrun   = overrun_r;

    // Next-state logic for the stage machine, the frame machine and the game counters.
    always_comb begin
        stage_s    = stage_r;
        frame_s    = frame_r;
        level_s    = level_r;
        food_s     = food_r;
        move_s     = move_r;
        div_s      = div_r;
        init_req_s = 1'b0;
        upd_req_s  = 1'b0;
        drawing_s  = drawing_r;
        overrun_s  = overrun_r;

        case (stage_r)
            ST_TITLE, ST_GAME_OVER: begin
                if (btn_edge_s) begin
                    stage_s    = ST_INIT;
                    init_req_s = 1'b1;
                end else begin
                    stage_s = stage_r;
                end
            end
            ST_INIT: begin
                if (init_done) begin
                    stage_s = ST_PLAYING;
                end else begin
                    stage_s = stage_r;
                end
            end
            ST_PLAYING: begin
                stage_s = stage_r;
            end
            default: begin
                stage_s = ST_TITLE;
            end
        endcase

        case (frame_r)
            F_IDLE: begin
                if (tick_s) begin
                    if ((stage_r == ST_PLAYING) && (move_r == (div_r - ONE))) begin
                        upd_req_s = 1'b1;
                        move_s    = {CNT_W{1'b0}};
                        frame_s   = F_UPD;
                    end else begin
                        if (stage_r == ST_PLAYING) begin
                            move_s = move_r + ONE;
                        end else begin
                            move_s = move_r;
                        end
                        drawing_s = 1'b1;
                        frame_s   = F_DRAW;
                    end
                end else begin
                    frame_s = F_IDLE;
                end
            end
            F_UPD: begin
                if (tick_s) begin
                    overrun_s = 1'b1;
                end else begin
                    overrun_s = overrun_r;
                end
                if (upd_done) begin
                    if (ate_food) begin
                        if (food_r == FOOD_LAST) begin
                            food_s  = {CNT_W{1'b0}};
                            level_s = (level_r == 4'd15) ? 4'd15 : (level_r + 4'd1);
                            div_s   = div_step_down(div_r, DIV_MIN);
                        end else begin
                            food_s = food_r + ONE;
                        end
                    end else begin
                        food_s = food_r;
                    end
                    if (collision && (stage_r == ST_PLAYING)) begin
                        stage_s = ST_GAME_OVER;
                    end else begin
                        stage_s = stage_s;
                    end
                    drawing_s = 1'b1;
                    frame_s   = F_DRAW;
                end else begin
                    frame_s = F_UPD;
                end
            end
            F_DRAW: begin
                if (tick_s) begin
                    overrun_s = 1'b1;
                end else begin
                    overrun_s = overrun_r;
                end
                if (draw_done) begin
                    drawing_s = 1'b0;
                    frame_s   = F_IDLE;
                end else begin
                    frame_s = F_DRAW;
                end
            end
            default: begin
                drawing_s = 1'b0;
                frame_s   = F_IDLE;
            end
        endcase

        // Entering play starts a fresh game regardless of frame activity.
        if ((stage_r == ST_INIT) && init_done) begin
            level_s = 4'd0;
            food_s  = {CNT_W{1'b0}};
            move_s  = {CNT_W{1'b0}};
            div_s   = DIV_INIT;
        end else begin
            level_s = level_s;
        end
    end

    // State and output registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stage_r    <= ST_TITLE;
            frame_r    <= F_IDLE;
            level_r    <= 4'd0;
            food_r     <= {CNT_W{1'b0}};
            move_r     <= {CNT_W{1'b0}};
            div_r      <= DIV_INIT;
            init_req_r <= 1'b0;
            upd_req_r  <= 1'b0;
            drawing_r  <= 1'b0;
            overrun_r  <= 1'b0;
            btn_q_r    <= 1'b0;
        end else begin
            stage_r    <= stage_s;
            frame_r    <= frame_s;
            level_r    <= level_s;
            food_r     <= food_s;
            move_r     <= move_s;
            div_r      <= div_s;
            init_req_r <= init_req_s;
            upd_req_r  <= upd_req_s;
            drawing_r  <= drawing_s;
            overrun_r  <= overrun_s;
            btn_q_r    <= start_btn;
        end
    end

endmodule

// File: tb/tb_snake_frame_sched.sv
// Randomized self-checking bench for snake_frame_sched against a behavioural game model.
module tb_snake_frame_sched;

    localparam int FC  = 10;
    localparam int MDI = 3;
    localparam int MDM = 2;
    localparam int FPL = 4;

    logic        clock = 1'b0;
    logic        resetn;
    logic        start_btn, init_done, upd_done, collision, ate_food, draw_done;
    logic [31:0] rstage;
    logic        init_req, upd_req, isDrawing, overrun;
    logic [3:0]  level;

    snake_frame_sched #(
        .FRAME_CYCLES   (FC),
        .MOVE_DIV_INIT  (MDI),
        .MOVE_DIV_MIN   (MDM),
        .FOOD_PER_LEVEL (FPL),
        .CW             (4)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .start_btn (start_btn),
        .init_done (init_done),
        .upd_done  (upd_done),
        .collision (collision),
        .ate_food  (ate_food),
        .draw_done (draw_done),
        .rstage    (rstage),
        .init_req  (init_req),
        .upd_req   (upd_req),
        .isDrawing (isDrawing),
        .level     (level),
        .overrun   (overrun)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model: game state as plain integers.
    int m_t, m_stage, m_level, m_food, m_div, m_moves;
    bit m_prev_btn, m_init_req, m_upd_req, m_drawing, m_waiting_upd, m_overrun;

    // Engine/player stimulus state.
    int init_wait, upd_wait, draw_wait, btn_hold, ate_pct;
    bit force_collide, withhold, rnd_mode;

    task automatic model_reset();
        m_t = 0; m_stage = 0; m_level = 0; m_food = 0; m_div = MDI; m_moves = 0;
        m_prev_btn = 0; m_init_req = 0; m_upd_req = 0; m_drawing = 0;
        m_waiting_upd = 0; m_overrun = 0;
        init_wait = 0; upd_wait = 0; draw_wait = -1;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        int  st;
        bit  tick, edge_seen, busy;
        st        = m_stage;
        tick      = ((m_t % FC) == FC - 1);
        edge_seen = start_btn && !m_prev_btn;
        busy      = m_waiting_upd || m_drawing;
        m_init_req = 0;
        m_upd_req  = 0;
        if ((st == 0 || st == 3) && edge_seen) begin
            m_stage = 1;
            m_init_req = 1;
        end
        if (st == 1 && init_done) begin
            m_stage = 2; m_level = 0; m_food = 0; m_moves = 0; m_div = MDI;
        end
        if (!busy) begin
            if (tick) begin
                if (st == 2 && m_moves == m_div - 1) begin
                    m_upd_req = 1; m_moves = 0; m_waiting_upd = 1;
                end else begin
                    if (st == 2) m_moves++;
                    m_drawing = 1;
                end
            end
        end else begin
            if (tick) m_overrun = 1;
            if (m_waiting_upd) begin
                if (upd_done) begin
                    if (ate_food) begin
                        m_food++;
                        if (m_food == FPL) begin
                            m_food = 0;
                            if (m_level < 15) m_level++;
                            m_div = (m_div - 1 < MDM) ? MDM : m_div - 1;
                        end
                    end
                    if (collision && st == 2) m_stage = 3;
                    m_waiting_upd = 0;
                    m_drawing = 1;
                end
            end else if (draw_done) begin
                m_drawing = 0;
            end
        end
        m_prev_btn = start_btn;
        m_t++;
    endtask

    // Choose inputs for the coming cycle, acting as player and engines.
    task automatic drive_inputs();
        init_done = 1'b0;
        upd_done  = 1'b0;
        draw_done = 1'b0;
        collision = 1'($urandom % 2);
        ate_food  = 1'($urandom % 2);
        if (rnd_mode) begin
            start_btn = ($urandom % 12 == 0);
        end else if (btn_hold > 0) begin
            start_btn = 1'b1;
            btn_hold--;
        end else begin
            start_btn = 1'b0;
        end
        if (m_init_req) init_wait = $urandom_range(1, 4);
        if (init_wait > 0) begin
            init_wait--;
            if (init_wait == 0) init_done = 1'b1;
        end
        if (m_upd_req) upd_wait = $urandom_range(1, 3);
        if (upd_wait > 0) begin
            upd_wait--;
            if (upd_wait == 0) begin
                upd_done = 1'b1;
                if (rnd_mode && ($urandom % 10 == 0)) force_collide = 1;
                collision = force_collide;
                ate_food  = force_collide || ($urandom % 100 < ate_pct);
                force_collide = 0;
            end
        end
        if (m_drawing && !m_waiting_upd) begin
            if (draw_wait < 0) draw_wait = withhold ? 14 : $urandom_range(1, 3);
            draw_wait--;
            if (draw_wait == 0) begin
                draw_done = 1'b1;
                draw_wait = -1;
                withhold  = 0;
            end
        end
    endtask

    task automatic compare_all();
        check_val("rstage",    rstage,    32'(m_stage));
        check_val("level",     level,     32'(m_level));
        check_val("init_req",  init_req,  32'(m_init_req));
        check_val("upd_req",   upd_req,   32'(m_upd_req));
        check_val("isDrawing", isDrawing, 32'(m_drawing));
        check_val("overrun",   overrun,   32'(m_overrun));
    endtask

    task automatic one_cycle();
        drive_inputs();
        model_step();
        @(posedge clock);
        #1;
        compare_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) one_cycle();
    endtask

    task automatic wait_stage(input int target, input int budget);
        int k;
        k = 0;
        while (m_stage != target && k < budget) begin
            one_cycle();
            k++;
        end
        check_val("reach_stage", rstage, 32'(target));
    endtask

    initial begin
        start_btn = 1'b0; init_done = 1'b0; upd_done = 1'b0;
        collision = 1'b0; ate_food = 1'b0; draw_done = 1'b0;
        btn_hold = 0; ate_pct = 100; force_collide = 0; withhold = 0; rnd_mode = 0;
        resetn = 1'b0;
        model_reset();
        #2;
        compare_all();
        repeat (2) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;

        // Title screen: a draw on every frame.
        run(35);

        // Start a game and eat on every move until the divider reaches its floor.
        btn_hold = 3;
        wait_stage(2, 60);
        run(450);
        check_val("level_after_feast", level, 32'(m_level));

        // Collision together with food: game over, food counted, draw still runs.
        ate_pct = 50;
        force_collide = 1;
        wait_stage(3, 200);
        run(30);

        // Restart from game over.
        btn_hold = 2;
        wait_stage(1, 20);
        wait_stage(2, 20);

        // Withheld draw_done across a tick.
        run(25);
        withhold = 1;
        run(60);
        check_val("overrun_sticky", overrun, 32'd1);

        // Randomized play, restarts and noise.
        rnd_mode = 1;
        run(1500);
        rnd_mode = 0;

        // Asynchronous reset in the middle of a draw.
        begin
            int k;
            k = 0;
            while (!m_drawing && k < 40) begin
                one_cycle();
                k++;
            end
            check_val("reach_draw", isDrawing, 32'd1);
        end
        resetn = 1'b0;
        #1;
        model_reset();
        compare_all();
        start_btn = 1'b0;
        @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        run(40);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
